// File: rtl/frame_loader.sv
// Writer side of the cube display path: assembles a header + 64-row byte stream in a shadow
// buffer and commits it atomically to frame_cube_flat, pulsing sync on the first visible cycle.
module frame_loader #(
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter int unsigned TO_W    = 20,
    parameter int unsigned TIMEOUT = 500000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [511:0] frame_cube_flat,
    output logic         sync,
    output logic         busy,
    output logic         frame_err,
    output logic [7:0]   frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Abort fires on the idle edge that would take the counter to TIMEOUT.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t            r_state;
    logic [511:0]      r_shadow;
    logic [511:0]      r_frame;
    logic [5:0]        r_row;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_sync;
    logic              r_err;
    logic [7:0]        r_count;
    logic              w_accept;

    assign in_ready        = (r_state != ST_COMMIT);
    assign busy            = (r_state == ST_LOAD) || (r_state == ST_COMMIT);
    assign w_accept        = in_valid && in_ready;
    assign frame_cube_flat = r_frame;
    assign sync            = r_sync;
    assign frame_err       = r_err;
    assign frame_count     = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_shadow <= '0;
            r_frame  <= '0;
            r_row    <= '0;
            r_to_cnt <= '0;
            r_sync   <= 1'b0;
            r_err    <= 1'b0;
            r_count  <= '0;
        end else begin
            r_sync <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && (in_data == HEADER)) begin
                        r_state  <= ST_LOAD;
                        r_row    <= '0;
                        r_to_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        // A HEADER-valued byte here is row data, not a restart.
                        r_shadow[{r_row, 3'b000} +: 8] <= in_data;
                        r_row    <= r_row + 6'd1;
                        r_to_cnt <= '0;
                        if (r_row == 6'd63) begin
                            r_state <= ST_COMMIT;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        r_state  <= ST_IDLE;
                        r_err    <= 1'b1;
                        r_to_cnt <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                ST_COMMIT: begin
                    r_frame <= r_shadow;
                    r_sync  <= 1'b1;
                    r_count <= r_count + 8'd1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
